// File: rtl/hazard_unit_pkg.sv
// Shared types for the hazard unit: divider FSM state encoding and
// E-stage forward-select codes.
package hazard_unit_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } divState_t;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

endpackage

// File: rtl/hazard_div_fsm.sv
// Divide sequencer: issues a one-cycle start, holds E until the divider
// answers, and cancels the operation on an exception in M.
module hazard_div_fsm
    import hazard_unit_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      divE,
    input  logic      div_ready,
    input  logic      exceptM,
    output logic      divStall,
    output logic      div_start,
    output logic      div_abort,
    output divState_t divState
);

    divState_t state;
    divState_t stateNext;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= DIV_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        div_start = 1'b0;
        div_abort = 1'b0;
        case (state)
            DIV_IDLE: begin
                if (divE && !exceptM) begin
                    div_start = !rst;
                    stateNext = DIV_BUSY;
                end
            end
            DIV_BUSY: begin
                // An exception wins over a simultaneous div_ready.
                if (exceptM) begin
                    div_abort = !rst;
                    stateNext = DIV_IDLE;
                end else if (div_ready) begin
                    stateNext = DIV_DONE;
                end
            end
            // The finished div is still in E here; do not restart it.
            DIV_DONE: stateNext = DIV_IDLE;
            default:  stateNext = DIV_IDLE;
        endcase
    end

    assign divStall = ((state == DIV_IDLE) && divE) || (state == DIV_BUSY);
    assign divState = state;

endmodule

// File: rtl/hazard_unit.sv
// Stall/flush/forward generator for the 5-stage pipeline.
// Optional HAZ_PERF_CNT_EN adds saturating stall/flush/div counters.
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rsD,
    input  logic [REG_AW-1:0] rtD,
    input  logic [REG_AW-1:0] rsE,
    input  logic [REG_AW-1:0] rtE,
    input  logic [REG_AW-1:0] writeregE,
    input  logic [REG_AW-1:0] writeregM,
    input  logic [REG_AW-1:0] writeregW,
    input  logic              regwriteE,
    input  logic              regwriteM,
    input  logic              regwriteW,
    input  logic              memtoregE,
    input  logic              memtoregM,
    input  logic              branchD,
    input  logic              jrD,
    input  logic              divE,
    input  logic              div_ready,
    input  logic              exceptM,
    output logic              forwardaD,
    output logic              forwardbD,
    output logic [1:0]        forwardaE,
    output logic [1:0]        forwardbE,
    output logic              stallF,
    output logic              stallD,
    output logic              stallE,
    output logic              stallM,
    output logic              stallW,
    output logic              flushD,
    output logic              flushE,
    output logic              flushM,
    output logic              flushW,
    output logic              div_start,
    output logic              div_abort
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic [CNT_W-1:0]  div_cnt
`endif
);

    logic      lwStall;
    logic      brStall;
    logic      divStall;
    logic      rsHitE;
    logic      rtHitE;
    logic      rsHitLoadM;
    logic      rtHitLoadM;
    divState_t divState;

    // M has priority over W since it holds the younger result.
    function automatic logic [1:0] fwdSel(
        input logic [REG_AW-1:0] src,
        input logic              wrM,
        input logic [REG_AW-1:0] dstM,
        input logic              wrW,
        input logic [REG_AW-1:0] dstW
    );
        if ((src != '0) && wrM && (dstM == src)) begin
            return FWD_M;
        end else if ((src != '0) && wrW && (dstW == src)) begin
            return FWD_W;
        end
        return FWD_RF;
    endfunction

    hazard_div_fsm uDivFsm (
        .clk       (clk),
        .rst       (rst),
        .divE      (divE),
        .div_ready (div_ready),
        .exceptM   (exceptM),
        .divStall  (divStall),
        .div_start (div_start),
        .div_abort (div_abort),
        .divState  (divState)
    );

    always_comb begin
        forwardaE = fwdSel(rsE, regwriteM, writeregM, regwriteW, writeregW);
        forwardbE = fwdSel(rtE, regwriteM, writeregM, regwriteW, writeregW);
        forwardaD = (rsD != '0) && regwriteM && (writeregM == rsD);
        forwardbD = (rtD != '0) && regwriteM && (writeregM == rtD);
    end

    always_comb begin
        lwStall    = memtoregE && ((rtE == rsD) || (rtE == rtD));
        rsHitE     = regwriteE && (writeregE == rsD);
        rtHitE     = regwriteE && (writeregE == rtD);
        rsHitLoadM = memtoregM && (writeregM == rsD);
        rtHitLoadM = memtoregM && (writeregM == rtD);
        // jr only reads rs, so rt hazards stall branches alone.
        brStall    = (branchD && (rsHitE || rtHitE || rsHitLoadM || rtHitLoadM))
                   || (jrD && (rsHitE || rsHitLoadM));
    end

    always_comb begin
        stallF = 1'b0;
        stallD = 1'b0;
        stallE = 1'b0;
        stallM = 1'b0;
        stallW = 1'b0;
        flushD = 1'b0;
        flushE = 1'b0;
        flushM = 1'b0;
        flushW = 1'b0;
        if (exceptM) begin
            flushD = 1'b1;
            flushE = 1'b1;
            flushM = 1'b1;
            flushW = 1'b1;
        end else begin
            stallF = lwStall || brStall || divStall;
            stallD = lwStall || brStall || divStall;
            stallE = divStall;
            flushE = (lwStall || brStall) && !divStall;
            flushM = divStall;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
            div_cnt   <= '0;
        end else begin
            if (stallD && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
            if (exceptM && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
            if (div_start && (div_cnt != '1)) div_cnt <= div_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: directed test-plan cases then random
// traffic, each cycle checked against a behavioural model.
module tb_hazard_unit;

    localparam int REG_AW = 5;
    localparam int CNT_W  = 32;
    localparam int VW     = 17;

    logic clk = 1'b0;
    logic rst;
    logic [REG_AW-1:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
    logic regwriteE, regwriteM, regwriteW, memtoregE, memtoregM;
    logic branchD, jrD, divE, div_ready, exceptM;
    logic forwardaD, forwardbD;
    logic [1:0] forwardaE, forwardbE;
    logic stallF, stallD, stallE, stallM, stallW;
    logic flushD, flushE, flushM, flushW, div_start, div_abort;
`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt, flush_cnt, div_cnt;
    logic [3*CNT_W-1:0] cnt_q[$];
    logic [CNT_W-1:0] mStallCnt = '0, mFlushCnt = '0, mDivCnt = '0;
`endif

    logic [VW-1:0] exp_q[$];
    int compared = 0;
    int mismatched = 0;
    int cycleNo = 0;

    // Model of the divide sequencer: in flight, or finishing this cycle.
    bit mBusy = 1'b0;
    bit mDone = 1'b0;

    always #5 clk = ~clk;

    hazard_unit #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
        .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
        .memtoregE(memtoregE), .memtoregM(memtoregM), .branchD(branchD),
        .jrD(jrD), .divE(divE), .div_ready(div_ready), .exceptM(exceptM),
        .forwardaD(forwardaD), .forwardbD(forwardbD),
        .forwardaE(forwardaE), .forwardbE(forwardbE),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
        .stallW(stallW), .flushD(flushD), .flushE(flushE), .flushM(flushM),
        .flushW(flushW), .div_start(div_start), .div_abort(div_abort)
`ifdef HAZ_PERF_CNT_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .div_cnt(div_cnt)
`endif
    );

    function automatic logic [VW-1:0] actVec();
        return {forwardaD, forwardbD, forwardaE, forwardbE,
                stallF, stallD, stallE, stallM, stallW,
                flushD, flushE, flushM, flushW, div_start, div_abort};
    endfunction

    function automatic logic [1:0] refFwd(input logic [REG_AW-1:0] src);
        if (src == 0) return 2'b00;
        if (regwriteM && writeregM == src) return 2'b10;
        if (regwriteW && writeregW == src) return 2'b01;
        return 2'b00;
    endfunction

    task automatic checkNow(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", name, cycleNo, act, exp);
        end
    endtask

    task automatic clearInputs();
        rsD = 0; rtD = 0; rsE = 0; rtE = 0;
        writeregE = 0; writeregM = 0; writeregW = 0;
        regwriteE = 0; regwriteM = 0; regwriteW = 0;
        memtoregE = 0; memtoregM = 0; branchD = 0; jrD = 0;
        divE = 0; div_ready = 0; exceptM = 0;
    endtask

    // Compute this cycle's expected outputs from the current inputs, queue
    // them, advance the model, and move to the next cycle.
    task automatic step();
        logic lw, br, ds, st, ab, hold;
        logic fd, fe, fm, fw, sF, sE;
        lw = memtoregE && (rtE == rsD || rtE == rtD);
        br = 1'b0;
        if (branchD || jrD) begin
            if (regwriteE && writeregE == rsD) br = 1'b1;
            if (memtoregM && writeregM == rsD) br = 1'b1;
            if (branchD && regwriteE && writeregE == rtD) br = 1'b1;
            if (branchD && memtoregM && writeregM == rtD) br = 1'b1;
        end
        ds = mBusy || (!mDone && divE);
        st = !mBusy && !mDone && divE && !exceptM && !rst;
        ab = mBusy && exceptM && !rst;
        if (exceptM) begin
            sF = 0; sE = 0; fd = 1; fe = 1; fm = 1; fw = 1;
        end else begin
            sF = lw || br || ds; sE = ds; fd = 0; fe = (lw || br) && !ds; fm = ds; fw = 0;
        end
        hold = sF;
        exp_q.push_back({rsD != 0 && regwriteM && writeregM == rsD,
                         rtD != 0 && regwriteM && writeregM == rtD,
                         refFwd(rsE), refFwd(rtE),
                         sF, sF, sE, 1'b0, 1'b0, fd, fe, fm, fw, st, ab});
`ifdef HAZ_PERF_CNT_EN
        cnt_q.push_back({mStallCnt, mFlushCnt, mDivCnt});
        if (rst) begin
            mStallCnt = 0; mFlushCnt = 0; mDivCnt = 0;
        end else begin
            if (hold && mStallCnt != '1) mStallCnt++;
            if (exceptM && mFlushCnt != '1) mFlushCnt++;
            if (st && mDivCnt != '1) mDivCnt++;
        end
`endif
        if (rst || exceptM) begin
            mBusy = 0; mDone = 0;
        end else if (st) begin
            mBusy = 1;
        end else if (mBusy && div_ready) begin
            mBusy = 0; mDone = 1;
        end else begin
            mDone = 0;
        end
        @(posedge clk);
        #1;
        cycleNo++;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [VW-1:0] e;
            e = exp_q.pop_front();
            compared++;
            if (actVec() !== e) begin
                mismatched++;
                $display("FAIL cycle_vec cycle=%0d got=%b expected=%b", cycleNo, actVec(), e);
            end
        end
`ifdef HAZ_PERF_CNT_EN
        if (cnt_q.size() > 0) begin
            logic [3*CNT_W-1:0] c;
            c = cnt_q.pop_front();
            compared++;
            if ({stall_cnt, flush_cnt, div_cnt} !== c) begin
                mismatched++;
                $display("FAIL counters cycle=%0d got=%h expected=%h", cycleNo,
                         {stall_cnt, flush_cnt, div_cnt}, c);
            end
        end
`endif
    end

    initial begin
        clearInputs();
        rst = 1;
        @(posedge clk); #1;
        checkNow("reset_outputs", 32'(actVec()), 32'd0);
        step();
        rst = 0;
        step();

        // Forwarding priority M over W, and r0 never forwarded.
        writeregM = 8; regwriteM = 1; rsE = 8; regwriteW = 1; writeregW = 8;
        #1 checkNow("fwd_m", 32'(forwardaE), 32'h2);
        step();
        regwriteM = 0;
        #1 checkNow("fwd_w", 32'(forwardaE), 32'h1);
        step();
        rsE = 0;
        #1 checkNow("fwd_r0", 32'(forwardaE), 32'h0);
        step();
        clearInputs();

        // Load-use: one stall cycle, cleared when the load is in M.
        memtoregE = 1; rtE = 9; rsD = 9;
        #1 checkNow("lw_stall", 32'({stallF, stallD, flushE}), 32'h7);
        step();
        memtoregE = 0; rtE = 0; memtoregM = 1; regwriteM = 1; writeregM = 9;
        #1 checkNow("lw_clear", 32'({stallF, stallD, flushE}), 32'h0);
        step();
        clearInputs();

        // Branch on an ALU result in E, then forwarded from M.
        branchD = 1; rsD = 4; regwriteE = 1; writeregE = 4;
        #1 checkNow("br_stall", 32'({stallD, flushE}), 32'h3);
        step();
        regwriteE = 0; writeregE = 0; regwriteM = 1; writeregM = 4;
        #1 checkNow("br_fwd", 32'({stallD, forwardaD}), 32'h1);
        step();
        clearInputs();

        // Divide: start, 5 cycles to ready, then a DONE cycle.
        divE = 1;
        for (int i = 0; i < 6; i++) begin
            div_ready = (i == 5);
            #1 checkNow("div_hold", 32'({stallE, flushM, div_start}), {29'd0, 2'b11, i == 0});
            step();
        end
        div_ready = 0;
        #1 checkNow("div_done", 32'({stallE, flushM, div_start}), 32'h0);
        step();
        clearInputs();
        step();

        // Exception while busy: abort, everything flushed, late ready ignored.
        divE = 1;
        step(); step(); step();
        exceptM = 1;
        #1 checkNow("exc_flush", 32'({flushD, flushE, flushM, flushW, stallF, stallE, div_abort}),
                    32'b1111001);
        step();
        clearInputs(); div_ready = 1;
        #1 checkNow("exc_idle", 32'({stallE, div_abort, div_start}), 32'h0);
        step();
        clearInputs();
        step();

        // Reset mid-divide: no abort, quiet afterwards.
        divE = 1;
        step(); step();
        clearInputs(); rst = 1;
        #1 checkNow("rst_no_abort", 32'(div_abort), 32'h0);
        step();
        rst = 0;
        #1 checkNow("rst_quiet", 32'(actVec()), 32'h0);
`ifdef HAZ_PERF_CNT_EN
        checkNow("rst_stall_cnt", stall_cnt, 32'h0);
`endif
        step();

        for (int n = 0; n < 3000; n++) begin
            rsD = REG_AW'($urandom_range(0, 3)); rtD = REG_AW'($urandom_range(0, 3));
            rsE = REG_AW'($urandom_range(0, 3)); rtE = REG_AW'($urandom_range(0, 3));
            writeregE = REG_AW'($urandom_range(0, 3));
            writeregM = REG_AW'($urandom_range(0, 3));
            writeregW = REG_AW'($urandom_range(0, 3));
            regwriteE = 1'($urandom_range(0, 1)); regwriteM = 1'($urandom_range(0, 1));
            regwriteW = 1'($urandom_range(0, 1));
            memtoregE = ($urandom_range(0, 3) == 0); memtoregM = ($urandom_range(0, 3) == 0);
            branchD = ($urandom_range(0, 3) == 0); jrD = ($urandom_range(0, 5) == 0);
            divE = ($urandom_range(0, 2) == 0); div_ready = ($urandom_range(0, 5) == 0);
            exceptM = ($urandom_range(0, 29) == 0); rst = ($urandom_range(0, 99) == 0);
            step();
        end
        clearInputs();
        rst = 0;
        @(negedge clk);
        @(negedge clk);
        checkNow("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Pipeline hazard and stall/flush generator for the 5-stage MIPS core.
- Produces every stall/flush consumed by the control and datapath pipeline registers, plus operand-forwarding selects.
- Sequences multi-cycle divide operations with a start/ready handshake to the divider.
- Flushes the whole pipe on an exception reported in M.

Parameters:
- REG_AW, 5, register-index width.
- CNT_W, 32, width of the performance counters (used only with HAZ_PERF_CNT_EN).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- rsD, rtD  in  REG_AW  source registers of the instruction in D
- rsE, rtE  in  REG_AW  source registers of the instruction in E
- writeregE, writeregM, writeregW  in  REG_AW  destination register per stage
- regwriteE, regwriteM, regwriteW  in  1  register-write enable per stage
- memtoregE, memtoregM  in  1  load in E / M
- branchD, jrD  in  1  branch or jr resolving in D
- divE  in  1  div/divu instruction in E
- div_ready  in  1  divider result valid (one-cycle pulse)
- exceptM  in  1  exception taken in M
- forwardaD, forwardbD  out  1  D-stage compare forward from M
- forwardaE, forwardbE  out  2  E operand select: 00 regfile, 01 W, 10 M
- stallF, stallD, stallE, stallM, stallW  out  1  hold pipeline register
- flushD, flushE, flushM, flushW  out  1  clear pipeline register to bubble
- div_start  out  1  one-cycle start pulse to the divider
- div_abort  out  1  cancel an in-flight divide

Behaviour:
- Reset: FSM=IDLE; all outputs 0; counters 0.
- Forwarding (combinational), register 0 is never forwarded:
  - forwardaE=10 if rsE!=0 && regwriteM && writeregM==rsE.
  - Otherwise forwardaE=01 if rsE!=0 && regwriteW && writeregW==rsE.
  - Otherwise forwardaE=00. forwardbE uses the same rules with rtE.
  - forwardaD = rsD!=0 && regwriteM && writeregM==rsD. forwardbD likewise with rtD.
- lwstall = memtoregE && (rtE==rsD || rtE==rtD).
- brstall = (branchD||jrD) && one of:
  - regwriteE && writeregE in {rsD,rtD}
  - memtoregM && writeregM in {rsD,rtD}
  - jr checks rsD only.
- Divider FSM states: IDLE, BUSY, DONE.
  - IDLE: if divE && !exceptM, pulse div_start for 1 cycle and go to BUSY.
  - BUSY: hold. On div_ready go to DONE.
  - DONE: lasts 1 cycle, then IDLE. div_start is suppressed so the same div is not restarted while it leaves E.
  - divstall = (IDLE && divE) || BUSY. It is asserted in the start cycle and deasserted in the DONE cycle.
- Stall/flush combining:
  - stallF=stallD = lwstall || brstall || divstall.
  - stallE = divstall.
  - flushE = (lwstall || brstall) && !divstall. Inserts a bubble behind a D stall.
  - flushM = divstall. Inserts a bubble while E holds the div.
  - stallM = stallW = 0.
- Exception has priority over everything:
  - exceptM=1 forces flushD=flushE=flushM=flushW=1 and all stalls to 0.
  - If the FSM is BUSY, div_abort pulses for 1 cycle and the FSM returns to IDLE next cycle.
  - A div_ready arriving in the same cycle as exceptM is ignored; the FSM goes to IDLE.
- A div_ready arriving in IDLE or DONE is ignored.
- Reset mid-divide: FSM returns to IDLE and div_abort is not asserted. The divider is reset by the same rst.

Optional Feature:
- Macro: HAZ_PERF_CNT_EN.
- With the macro: output ports stall_cnt (CNT_W), flush_cnt (CNT_W) and div_cnt (CNT_W) are present.
  - stall_cnt increments each cycle stallD=1.
  - flush_cnt increments each exceptM cycle.
  - div_cnt increments on each div_start.
  - Counters saturate at all-ones.
- Without the macro: the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared package: FSM state encoding (IDLE=0, BUSY=1, DONE=2) and forward-select constants (FWD_RF=00, FWD_W=01, FWD_M=10).
- One natural sub-module, hazard_div_fsm: the divider state machine producing divstall, div_start and div_abort.
- Forwarding and stall logic stay in hazard_unit.

Test Plan:
- writeregM=8, regwriteM=1, rsE=8, and W also writes 8 -> forwardaE=10. With regwriteM=0 -> 01. With rsE=0 -> 00.
- memtoregE=1, rtE=9, rsD=9 -> stallF=stallD=flushE=1 for exactly 1 cycle. Clears once the load reaches M.
- branchD=1, rsD=4, regwriteE=1, writeregE=4 -> brstall. Next cycle, with the instruction now in M and memtoregM=0 -> no stall, forwardaD=1.
- divE=1, div_ready pulsed 5 cycles after div_start -> div_start is high 1 cycle only. stallE=flushM=1 for 6 cycles, then 0 in the DONE cycle, with no second div_start.
- div BUSY, exceptM=1 at cycle 3 -> all flushes 1, stalls 0, div_abort 1 cycle, FSM IDLE. A div_ready arriving later is ignored.
- rst asserted while BUSY -> all outputs 0 next cycle; with HAZ_PERF_CNT_EN, stall_cnt=0.
